// File: rtl/issue_window_pkg.sv
`default_nettype none
// ============================================================================
// Module      : issue_window_pkg
// Description : Shared entry type, register-zero constant and lane-mask helper
//               for the in-order issue window.
// Revision    : 1.0 - initial release
// ============================================================================
package issue_window_pkg;

    localparam logic [4:0] REG_ZERO           = 5'd0;
    localparam int         C_PAYLOAD_MAX_W    = 64;
    localparam int         C_MAX_LANES        = 8;

    typedef struct packed {
        logic [C_PAYLOAD_MAX_W-1:0] payload;
        logic [4:0]                 rd;
        logic [4:0]                 rs1;
        logic [4:0]                 rs2;
        logic                       we;
    } issue_window_entry_t;

    // Length of the run of ones starting at bit 0; equals popcount for packed masks.
    function automatic logic [3:0] popcount_prefix(input logic [C_MAX_LANES-1:0] mask);
        logic [3:0] n;
        logic       run;
        n   = '0;
        run = 1'b1;
        for (int i = 0; i < C_MAX_LANES; i++) begin
            run = run & mask[i];
            n   = n + {3'b000, run};
        end
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/issue_window_hazard.sv
`default_nettype none
// ============================================================================
// Module      : issue_window_hazard
// Description : Combinational intra-group RAW check; masks issue candidates.
// Revision    : 1.0 - initial release
// ============================================================================
module issue_window_hazard
    import issue_window_pkg::*;
#(
    parameter int ISSUE_W = 2
) (
    input  issue_window_entry_t [ISSUE_W-1:0] entries_i,
    input  logic [ISSUE_W-1:0]                cand_i,
    output logic [ISSUE_W-1:0]                valid_o,
    output logic                              stall_o
);

    logic [ISSUE_W-1:0] w_conflict;
    logic               w_clear;
    logic               w_unused_fields;

    // Payloads, last-lane rd and lane-0 sources never feed the check.
    assign w_unused_fields = ^entries_i;

    always_comb begin
        w_conflict = '0;
        for (int k = 1; k < ISSUE_W; k++) begin
            for (int j = 0; j < k; j++) begin
                if (entries_i[j].we && (entries_i[j].rd != REG_ZERO) &&
                    ((entries_i[j].rd == entries_i[k].rs1) ||
                     (entries_i[j].rd == entries_i[k].rs2))) begin
                    w_conflict[k] = 1'b1;
                end
            end
        end
    end

    // A conflict on lane k holds back k and every younger lane.
    always_comb begin
        valid_o = '0;
        w_clear = 1'b0;
        for (int k = 0; k < ISSUE_W; k++) begin
            w_clear    = w_clear | w_conflict[k];
            valid_o[k] = cand_i[k] & ~w_clear;
        end
    end

    assign stall_o = |(cand_i & ~valid_o);

endmodule
`default_nettype wire

// File: rtl/issue_window.sv
`default_nettype none
// ============================================================================
// Module      : issue_window
// Description : Multi-wide in-order issue buffer (circular, DEPTH entries)
//               with intra-group RAW hold-back and full flush.
// Options     : ISSUE_WINDOW_STALL_CNT_EN adds hazard_stall_cnt_o.
// Revision    : 1.0 - initial release
// ============================================================================
module issue_window
    import issue_window_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int DEC_W     = 2,
    parameter int ISSUE_W   = 2,
    parameter int PAYLOAD_W = 64
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic                                flush_i,
    input  logic [DEC_W-1:0]                    in_valid_i,
    output logic                                in_ready_o,
    input  logic [DEC_W-1:0][PAYLOAD_W-1:0]     in_payload_i,
    input  logic [DEC_W-1:0][4:0]               in_rd_i,
    input  logic [DEC_W-1:0][4:0]               in_rs1_i,
    input  logic [DEC_W-1:0][4:0]               in_rs2_i,
    input  logic [DEC_W-1:0]                    in_we_i,
    output logic [ISSUE_W-1:0]                  out_valid_o,
    input  logic [ISSUE_W-1:0]                  out_ack_i,
    output logic [ISSUE_W-1:0][PAYLOAD_W-1:0]   out_payload_o,
    output logic [$clog2(DEPTH):0]              count_o,
    output logic                                empty_o
`ifdef ISSUE_WINDOW_STALL_CNT_EN
    ,
    output logic [31:0]                         hazard_stall_cnt_o
`endif
);

    localparam int C_PTR_W = $clog2(DEPTH);
    localparam int C_CNT_W = C_PTR_W + 1;

    issue_window_entry_t                r_mem_q [DEPTH];
    issue_window_entry_t                w_mem_d [DEPTH];
    logic [C_PTR_W-1:0]                 r_head_q, w_head_d;
    logic [C_PTR_W-1:0]                 r_tail_q, w_tail_d;
    logic [C_CNT_W-1:0]                 r_count_q, w_count_d;
    logic [C_CNT_W-1:0]                 w_free;
    logic [C_CNT_W-1:0]                 w_push_n;
    logic [C_CNT_W-1:0]                 w_pop_n;
    logic                               w_push;
    issue_window_entry_t [ISSUE_W-1:0]  w_head_ent;
    logic [ISSUE_W-1:0]                 w_cand;
    logic                               w_hazard_stall;

    // Readiness uses only the registered count: a same-cycle pop never frees space.
    assign w_free     = C_CNT_W'(DEPTH) - r_count_q;
    assign in_ready_o = (w_free >= C_CNT_W'(DEC_W));
    assign w_push     = in_ready_o && in_valid_i[0] && !flush_i;
    assign w_push_n   = w_push ? C_CNT_W'(popcount_prefix(C_MAX_LANES'(in_valid_i))) : '0;
    assign w_pop_n    = flush_i ? '0 : C_CNT_W'(popcount_prefix(C_MAX_LANES'(out_ack_i)));

    always_comb begin
        w_head_d  = r_head_q + C_PTR_W'(w_pop_n);
        w_tail_d  = r_tail_q + C_PTR_W'(w_push_n);
        w_count_d = r_count_q + w_push_n - w_pop_n;
        if (flush_i) begin
            w_head_d  = '0;
            w_tail_d  = '0;
            w_count_d = '0;
        end
    end

    always_comb begin
        w_mem_d = r_mem_q;
        for (int l = 0; l < DEC_W; l++) begin
            if (w_push && in_valid_i[l]) begin
                w_mem_d[r_tail_q + C_PTR_W'(l)] = '{
                    payload: C_PAYLOAD_MAX_W'(in_payload_i[l]),
                    rd:      in_rd_i[l],
                    rs1:     in_rs1_i[l],
                    rs2:     in_rs2_i[l],
                    we:      in_we_i[l]
                };
            end
        end
    end

    // Oldest entry sits on lane 0; pointer arithmetic wraps since DEPTH is a power of two.
    always_comb begin
        w_head_ent    = '0;
        w_cand        = '0;
        out_payload_o = '0;
        for (int k = 0; k < ISSUE_W; k++) begin
            w_head_ent[k]    = r_mem_q[r_head_q + C_PTR_W'(k)];
            w_cand[k]        = (C_CNT_W'(k) < r_count_q);
            out_payload_o[k] = PAYLOAD_W'(w_head_ent[k].payload);
        end
    end

    issue_window_hazard #(
        .ISSUE_W   (ISSUE_W)
    ) u_hazard (
        .entries_i (w_head_ent),
        .cand_i    (w_cand),
        .valid_o   (out_valid_o),
        .stall_o   (w_hazard_stall)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_head_q  <= '0;
            r_tail_q  <= '0;
            r_count_q <= '0;
        end else begin
            r_head_q  <= w_head_d;
            r_tail_q  <= w_tail_d;
            r_count_q <= w_count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        r_mem_q <= w_mem_d;
    end

    assign count_o = r_count_q;
    assign empty_o = (r_count_q == '0);

`ifdef ISSUE_WINDOW_STALL_CNT_EN
    logic [31:0] r_stall_cnt_q;
    logic [31:0] w_stall_cnt_d;

    // Saturating; survives flush and clears only on reset.
    always_comb begin
        w_stall_cnt_d = r_stall_cnt_q;
        if (w_hazard_stall && (r_stall_cnt_q != '1)) begin
            w_stall_cnt_d = r_stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_stall_cnt_q <= '0;
        end else begin
            r_stall_cnt_q <= w_stall_cnt_d;
        end
    end

    assign hazard_stall_cnt_o = r_stall_cnt_q;
`else
    logic w_stall_unused;
    assign w_stall_unused = w_hazard_stall;
`endif

    a_in_valid_packed: assert property (@(posedge clk_i) disable iff (rst_i)
        ((in_valid_i & (in_valid_i + DEC_W'(1))) == '0));

    a_ack_packed: assert property (@(posedge clk_i) disable iff (rst_i)
        ((out_ack_i & (out_ack_i + ISSUE_W'(1))) == '0));

    a_ack_within_valid: assert property (@(posedge clk_i) disable iff (rst_i)
        ((out_ack_i & ~out_valid_o) == '0));

endmodule
`default_nettype wire
